// File: rtl/vga_map_sched.sv
// vga_map_sched: arbitrates a host port and a pattern-fill engine onto one registered map port.
// Optional fill abort is compiled in when VGA_MAP_SCHED_ABORT_EN is defined.
module vga_map_sched #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  host_req_i,
    input  logic                  host_we_i,
    input  logic [ADDR_W-1:0]     host_addr_i,
    input  logic [DATA_W-1:0]     host_wdata_i,
    input  logic [DATA_W/8-1:0]   host_be_i,
    output logic                  host_gnt_o,
    output logic                  host_rvalid_o,
    output logic [DATA_W-1:0]     host_rdata_o,
    input  logic                  fill_start_i,
    input  logic [ADDR_W-1:0]     fill_base_i,
    input  logic [ADDR_W:0]       fill_len_i,
    input  logic [DATA_W-1:0]     fill_pattern_i,
    input  logic                  fill_abort_i,
    output logic                  fill_busy_o,
    output logic                  fill_done_o,
    output logic [ADDR_W-1:0]     map_addr_o,
    output logic [DATA_W-1:0]     map_wdata_o,
    output logic [DATA_W/8-1:0]   map_wen_o,
    input  logic [DATA_W-1:0]     map_rdata_i
);
    localparam int BE_W  = DATA_W / 8;
    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;
    state_t r_state, w_state_nxt;

    logic [ADDR_W-1:0] r_fill_addr;
    logic [LEN_W-1:0]  r_fill_left;
    logic [DATA_W-1:0] r_fill_pat;
    logic              r_fill_busy;
    logic              r_fill_done;
    logic              r_last_p1;
    logic              r_prio_fill;
    logic              r_rd_p1;
    logic              r_rvalid_p2;
    logic [DATA_W-1:0] r_rdata_p2;
    logic [ADDR_W-1:0] r_map_addr_p1;
    logic [DATA_W-1:0] r_map_wdata_p1;
    logic [BE_W-1:0]   r_map_wen_p1;

    logic w_start_ok;
    logic w_start_zero;
    logic w_start_fill;
    logic w_fill_req;
    logic w_abort;
    logic w_host_gnt;
    logic w_fill_gnt;
    logic w_fill_last;

    // A full map sweep is the longest useful fill; longer requests clamp to it.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] lim;
        lim = LEN_W'(1) << ADDR_W;
        return (len > lim) ? lim : len;
    endfunction

    always_comb begin
        w_state_nxt  = r_state;
        w_fill_req   = 1'b0;
        w_abort      = 1'b0;
        w_start_ok   = (r_state == S_IDLE) && !r_fill_busy && fill_start_i;
        w_start_zero = w_start_ok && (fill_len_i == '0);
        w_start_fill = w_start_ok && (fill_len_i != '0);
        if (r_state == S_FILL) begin
`ifdef VGA_MAP_SCHED_ABORT_EN
            w_abort = fill_abort_i;
`else
            w_abort = fill_abort_i & 1'b0;
`endif
            w_fill_req = !w_abort;
        end
        // On contention r_prio_fill picks the winner; it alternates while a fill runs.
        w_host_gnt  = rstn_i && host_req_i && (!w_fill_req || !r_prio_fill);
        w_fill_gnt  = w_fill_req && (!host_req_i || r_prio_fill);
        w_fill_last = w_fill_gnt && (r_fill_left == LEN_W'(1));
        case (r_state)
            S_IDLE: if (w_start_fill) w_state_nxt = S_FILL;
            S_FILL: if (w_abort || w_fill_last) w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Stage p1: granted access registered onto the map port.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_map_addr_p1  <= '0;
            r_map_wdata_p1 <= '0;
            r_map_wen_p1   <= '0;
            r_rd_p1        <= 1'b0;
        end else begin
            r_map_wen_p1 <= '0;
            r_rd_p1      <= w_host_gnt && !host_we_i;
            if (w_host_gnt) begin
                r_map_addr_p1  <= host_addr_i;
                r_map_wdata_p1 <= host_wdata_i;
                r_map_wen_p1   <= host_we_i ? host_be_i : '0;
            end else if (w_fill_gnt) begin
                r_map_addr_p1  <= r_fill_addr;
                r_map_wdata_p1 <= r_fill_pat;
                r_map_wen_p1   <= '1;
            end
        end
    end

    // Stage p2: map read data, presented while the read address is on the port, is captured.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rvalid_p2 <= 1'b0;
            r_rdata_p2  <= '0;
        end else begin
            r_rvalid_p2 <= r_rd_p1;
            if (r_rd_p1) r_rdata_p2 <= map_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_fill_addr <= '0;
            r_fill_left <= '0;
            r_fill_pat  <= '0;
            r_fill_busy <= 1'b0;
            r_fill_done <= 1'b0;
            r_last_p1   <= 1'b0;
            r_prio_fill <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_fill_addr <= fill_base_i;
                r_fill_left <= sat_len(fill_len_i);
                r_fill_pat  <= fill_pattern_i;
            end else if (w_fill_gnt) begin
                r_fill_addr <= r_fill_addr + ADDR_W'(1);
                r_fill_left <= r_fill_left - LEN_W'(1);
            end
            r_last_p1   <= w_fill_last;
            // Busy spans until the last fill write has left the map port.
            r_fill_done <= r_last_p1 || w_abort || w_start_zero;
            if (w_start_fill)               r_fill_busy <= 1'b1;
            else if (r_last_p1 || w_abort)  r_fill_busy <= 1'b0;
            if (r_state == S_IDLE) r_prio_fill <= 1'b0;
            else if (w_host_gnt)   r_prio_fill <= 1'b1;
            else if (w_fill_gnt)   r_prio_fill <= 1'b0;
        end
    end

    assign host_gnt_o    = w_host_gnt;
    assign host_rvalid_o = r_rvalid_p2;
    assign host_rdata_o  = r_rdata_p2;
    assign fill_busy_o   = r_fill_busy;
    assign fill_done_o   = r_fill_done;
    assign map_addr_o    = r_map_addr_p1;
    assign map_wdata_o   = r_map_wdata_p1;
    assign map_wen_o     = r_map_wen_p1;

endmodule
